muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative, parametrised multiply/divide unit that owns the architectural HI/LO registers.
- Succeeds the single-cycle combinational multiply path in the ALU.
- Sits beside the EX-stage ALU. The pipeline stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.
- Adds signed/unsigned divide, MTHI/MTLO, flush on exception, and a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/HI/LO width; must be even and ≥ 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset, sampled at rising edge of clk.
- start  in  1  request; accepted only when busy=0.
- op  in  3  operation code (see Behaviour).
- a  in  WIDTH  rs operand (multiplicand / dividend / MT source).
- b  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  cancel in-flight operation (exception/branch squash).
- busy  out  1  operation in progress; pipeline stalls MFHI/MFLO/new muldiv.
- done  out  1  one-cycle pulse, HI/LO hold the new result in this cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst_n=0 at edge): hi=0, lo=0, busy=0, done=0, FSM=IDLE. Applies mid-operation; any partial result is discarded.
- op codes:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 MADD, 111 MSUB exist only with the optional feature; otherwise they are treated as no-op (accepted, nothing written, no done).
- Accept: start=1 and busy=0 at edge E0. start while busy=1 is ignored (not queued). a/b are captured at E0 and need not be held.
- MTHI/MTLO:
  - hi (resp. lo) <= a at E0.
  - No busy, no done.
  - Back-to-back accepted every cycle.
- FSM: IDLE -> RUN (WIDTH cycles, one radix-2 step per cycle) -> FIX (sign correction, HI/LO write) -> IDLE.
- Multiply latency:
  - busy=1 in the cycles after E0 through edge E0+WIDTH+1.
  - HI/LO are written at edge E0+WIDTH+1.
  - done=1, busy=0 in the following cycle.
  - A new start is accepted in the done cycle.
- Divide latency is identical to multiply latency.
- Arithmetic:
  - Signed ops take magnitudes of a and b, compute unsigned, then correct signs in FIX.
  - Product {hi,lo} = exact 2*WIDTH-bit product, negated if sign(a)≠sign(b).
  - Quotient lo, truncated toward zero, negated if signs differ.
  - Remainder hi takes the sign of the dividend.
  - Unsigned ops skip all negation.
- Divide by zero (b=0, DIV or DIVU):
  - No iteration; FSM goes straight to FIX.
  - lo = all ones, hi = a.
  - done is asserted at cycle E0+2 (HI/LO written at edge E0+1).
- Signed overflow (DIV MIN/-1): lo = MIN, hi = 0, at normal latency.
- flush=1 at an edge while busy:
  - FSM -> IDLE, busy=0, done stays 0.
  - hi/lo unchanged.
  - A start in the same cycle as flush is ignored.
- flush while idle has no effect.
- rst_n takes priority over flush; flush takes priority over start.

Optional Feature:
- MULDIV_ACCUM_EN defined:
  - op 110 MADD gives {hi,lo} <= {hi,lo} + signed product.
  - op 111 MSUB gives {hi,lo} <= {hi,lo} − signed product.
  - Accumulation happens in FIX; latency is the same as MULT, and the result is modulo 2^(2*WIDTH).
- MULDIV_ACCUM_EN undefined: 110/111 behave as no-ops as stated above, and no accumulate adder is synthesized.

Decomposition:
- Package muldiv_pkg:
  - op code localparams (OP_MULT … OP_MSUB).
  - FSM state encoding (ST_IDLE, ST_RUN, ST_FIX).
- Sub-module muldiv_core: the shared WIDTH-step shift/add and restoring-subtract datapath (partial remainder/product, counter).
- muldiv_unit keeps the handshake, sign handling, HI/LO registers and the accumulate path.

Test Plan:
- MULT a=FFFFFFFD (−3), b=7 -> at done (cycle E0+WIDTH+2 = E0+34): hi=FFFFFFFF, lo=FFFFFFEB; busy high 33 cycles.
- MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; MULT of the same operands -> hi=0, lo=1.
- DIV a=FFFFFFF9 (−7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU with the same operands -> lo=7FFFFFFC, hi=1.
- Edge cases:
  - DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
  - DIVU a=64, b=0 -> done at E0+2, lo=FFFFFFFF, hi=00000064.
- Control:
  - start MULT, re-assert start at E0+5 -> ignored.
  - flush at E0+10 -> busy=0 next cycle, no done, hi/lo retain prior values.
  - Repeat with rst_n=0 mid-op -> hi=lo=0.
- With MULDIV_ACCUM_EN: MTHI 0, MTLO 5, then MADD 3×4 -> lo=0000_0011; MSUB 2×10 -> lo=FFFFFFFD, hi=FFFFFFFF.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states, op decode helpers.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Pipeline-side handshake bundle for muldiv_unit: request/operands in, busy/done and HI/LO out.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_core.sv
// Unsigned radix-2 datapath shared by multiply (shift/add) and divide (restoring subtract).
// One step per cycle while 'step' is high; 'last' flags the final (WIDTH-th) step.
module muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             div,
  input  logic [WIDTH-1:0] load_lo,
  input  logic [WIDTH-1:0] load_d,
  input  logic             step,
  output logic             last,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc_hi, acc_lo, opd;
  logic             div_r;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   sum, shifted, diff;
  logic [WIDTH-1:0] step_hi, step_lo;

  // NOTE: combinational logic uses blocking '=', sequential state uses non-blocking '<='.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted - {1'b0, opd};
    if (div_r) begin
      // Restore when the trial subtract goes negative; quotient bit enters at the bottom.
      step_hi = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // NOTE: pure datapath registers need no reset; every operation reloads them via 'load'.
  always_ff @(posedge clk) begin
    if (load) begin
      acc_hi <= '0;
      acc_lo <= load_lo;
      opd    <= load_d;
      div_r  <= div;
      cnt    <= '0;
    end else if (step) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign res_hi = acc_hi;
  assign res_lo = acc_lo;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO, with start/busy/done handshake and flush.
// Optional MADD/MSUB accumulate path is enabled by defining MULDIV_ACCUM_EN.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst_n,
  muldiv_if.slave  bus
);
  state_t             state, state_n;
  logic [2:0]         op_r;
  logic               neg_q, neg_r, dz_r;
  logic [WIDTH-1:0]   a_r, hi_r, lo_r;
  logic               done_r;

  logic               accept, mt_hi, mt_lo, wr_hilo;
  logic               sgn_in, div_in, div_zero;
  logic [WIDTH-1:0]   mag_a, mag_b, core_hi, core_lo, wr_hi, wr_lo;
  logic [2*WIDTH-1:0] prod_s;
  logic               core_last;

  always_comb begin
    sgn_in   = op_is_signed(bus.op);
    div_in   = op_is_div(bus.op);
    mag_a    = (sgn_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b    = (sgn_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    div_zero = div_in && (bus.b == '0);
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    mt_hi   = 1'b0;
    mt_lo   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          case (bus.op)
            OP_MTHI: mt_hi = 1'b1;
            OP_MTLO: mt_lo = 1'b1;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: accept = 1'b1;
`ifdef MULDIV_ACCUM_EN
            OP_MADD, OP_MSUB: accept = 1'b1;
`endif
            default: ;
          endcase
          if (accept) state_n = div_zero ? ST_FIX : ST_RUN;
        end
      end
      ST_RUN:  state_n = bus.flush ? ST_IDLE : (core_last ? ST_FIX : ST_RUN);
      ST_FIX:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    wr_hilo = (state == ST_FIX) && !bus.flush;
  end

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .load    (accept && !div_zero),
    .div     (div_in),
    .load_lo (div_in ? mag_a : mag_b),
    .load_d  (div_in ? mag_b : mag_a),
    .step    (state == ST_RUN),
    .last    (core_last),
    .res_hi  (core_hi),
    .res_lo  (core_lo)
  );

  // Sign correction and HI/LO write data, consumed only in FIX.
  always_comb begin
    prod_s = neg_q ? -{core_hi, core_lo} : {core_hi, core_lo};
    {wr_hi, wr_lo} = prod_s;
    if (dz_r) begin
      wr_hi = a_r;
      wr_lo = '1;
    end else if (op_is_div(op_r)) begin
      wr_lo = neg_q ? -core_lo : core_lo;
      wr_hi = neg_r ? -core_hi : core_hi;
    end
`ifdef MULDIV_ACCUM_EN
    else if (op_r == OP_MADD) begin
      {wr_hi, wr_lo} = {hi_r, lo_r} + prod_s;
    end else if (op_r == OP_MSUB) begin
      {wr_hi, wr_lo} = {hi_r, lo_r} - prod_s;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_r  <= bus.op;
      neg_q <= sgn_in && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      neg_r <= sgn_in && bus.a[WIDTH-1];
      dz_r  <= div_zero;
      a_r   <= bus.a;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      done_r <= wr_hilo;
      if (wr_hilo) begin
        hi_r <= wr_hi;
        lo_r <= wr_lo;
      end else begin
        if (mt_hi) hi_r <= bus.a;
        if (mt_lo) lo_r <= bus.a;
      end
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32): arithmetic, latency, MT ops, flush, reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Called at a negedge: request is sampled at the next posedge (E0); returns at the following negedge.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 32'hDEADBEEF;
    bus.b     = 32'h0BADF00D;
  endtask

  // lat = number of negedges after E0 at which done is seen; bcnt = cycles busy was high before that.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 1;
    bcnt = bus.busy ? 1 : 0;
    while (!bus.done && lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected %h", bus.hi, 32'h0); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected %h", bus.lo, 32'h0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mt();
    bus.start = 1'b1; bus.op = OP_MTHI; bus.a = 32'hA5A50001;
    @(negedge clk);
    checks++; if (bus.hi !== 32'hA5A50001) begin errors++; $display("FAIL mthi: got %h expected %h", bus.hi, 32'hA5A50001); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL mthi_hs: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
    bus.op = OP_MTLO; bus.a = 32'h5A5A0002;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.lo !== 32'h5A5A0002) begin errors++; $display("FAIL mtlo: got %h expected %h", bus.lo, 32'h5A5A0002); end
    checks++; if (bus.hi !== 32'hA5A50001) begin errors++; $display("FAIL mtlo_keep_hi: got %h expected %h", bus.hi, 32'hA5A50001); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL mtlo_hs: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_mult();
    vec_t v [6];
    int lat, bcnt;
    v[0] = {OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    v[1] = {OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    v[2] = {OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    v[3] = {OP_MULTU, 32'h80000000, 32'd4,        32'h00000002, 32'h00000000};
    v[4] = {OP_MULT,  32'h80000000, 32'd4,        32'hFFFFFFFE, 32'h00000000};
    v[5] = {OP_MULT,  32'hFFFFFFFF, 32'd0,        32'h00000000, 32'h00000000};
    for (int i = 0; i < 6; i++) begin
      launch(v[i].op, v[i].a, v[i].b);
      wait_done(lat, bcnt);
      checks++; if (lat !== 34) begin errors++; $display("FAIL mult%0d_latency: got %0d expected 34", i, lat); end
      checks++; if (bcnt !== 33) begin errors++; $display("FAIL mult%0d_busy_cycles: got %0d expected 33", i, bcnt); end
      checks++; if (bus.hi !== v[i].hi) begin errors++; $display("FAIL mult%0d_hi: got %h expected %h", i, bus.hi, v[i].hi); end
      checks++; if (bus.lo !== v[i].lo) begin errors++; $display("FAIL mult%0d_lo: got %h expected %h", i, bus.lo, v[i].lo); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mult%0d_done_pulse: got %b expected 0", i, bus.done); end
    end
  endtask

  task automatic test_div();
    vec_t v [6];
    int lat, bcnt;
    v[0] = {OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    v[1] = {OP_DIVU, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC};
    v[2] = {OP_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    v[3] = {OP_DIVU, 32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    v[4] = {OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    v[5] = {OP_DIVU, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      launch(v[i].op, v[i].a, v[i].b);
      wait_done(lat, bcnt);
      checks++; if (lat !== 34) begin errors++; $display("FAIL div%0d_latency: got %0d expected 34", i, lat); end
      checks++; if (bus.hi !== v[i].hi) begin errors++; $display("FAIL div%0d_hi: got %h expected %h", i, bus.hi, v[i].hi); end
      checks++; if (bus.lo !== v[i].lo) begin errors++; $display("FAIL div%0d_lo: got %h expected %h", i, bus.lo, v[i].lo); end
    end
  endtask

  task automatic test_div_by_zero();
    vec_t v [2];
    int lat, bcnt;
    v[0] = {OP_DIVU, 32'h00000064, 32'd0, 32'h00000064, 32'hFFFFFFFF};
    v[1] = {OP_DIV,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      launch(v[i].op, v[i].a, v[i].b);
      wait_done(lat, bcnt);
      checks++; if (lat !== 2) begin errors++; $display("FAIL dz%0d_latency: got %0d expected 2", i, lat); end
      checks++; if (bcnt !== 1) begin errors++; $display("FAIL dz%0d_busy_cycles: got %0d expected 1", i, bcnt); end
      checks++; if (bus.hi !== v[i].hi) begin errors++; $display("FAIL dz%0d_hi: got %h expected %h", i, bus.hi, v[i].hi); end
      checks++; if (bus.lo !== v[i].lo) begin errors++; $display("FAIL dz%0d_lo: got %h expected %h", i, bus.lo, v[i].lo); end
    end
  endtask

`ifdef MULDIV_ACCUM_EN
  task automatic test_accum();
    vec_t v [3];
    int lat, bcnt;
    @(negedge clk);
    launch(OP_MTHI, 32'h0, 32'h0);
    launch(OP_MTLO, 32'd5, 32'h0);
    v[0] = {OP_MADD, 32'd3,        32'd4,  32'h00000000, 32'h00000011};
    v[1] = {OP_MSUB, 32'd2,        32'd10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    v[2] = {OP_MADD, 32'hFFFFFFFF, 32'd3,  32'hFFFFFFFF, 32'hFFFFFFFA};
    for (int i = 0; i < 3; i++) begin
      launch(v[i].op, v[i].a, v[i].b);
      wait_done(lat, bcnt);
      checks++; if (lat !== 34) begin errors++; $display("FAIL acc%0d_latency: got %0d expected 34", i, lat); end
      checks++; if (bus.hi !== v[i].hi) begin errors++; $display("FAIL acc%0d_hi: got %h expected %h", i, bus.hi, v[i].hi); end
      checks++; if (bus.lo !== v[i].lo) begin errors++; $display("FAIL acc%0d_lo: got %h expected %h", i, bus.lo, v[i].lo); end
      @(negedge clk);
    end
  endtask
`else
  task automatic test_noop();
    logic [31:0] hi0, lo0;
    int act;
    @(negedge clk);
    launch(OP_MTHI, 32'h11112222, 32'h0);
    launch(OP_MTLO, 32'h33334444, 32'h0);
    hi0 = 32'h11112222;
    lo0 = 32'h33334444;
    launch(OP_MADD, 32'd3, 32'd4);
    launch(OP_MSUB, 32'd2, 32'd10);
    act = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy || bus.done) act++;
      @(negedge clk);
    end
    checks++; if (act !== 0) begin errors++; $display("FAIL noop_activity: got %0d busy/done cycles expected 0", act); end
    checks++; if (bus.hi !== hi0) begin errors++; $display("FAIL noop_hi: got %h expected %h", bus.hi, hi0); end
    checks++; if (bus.lo !== lo0) begin errors++; $display("FAIL noop_lo: got %h expected %h", bus.lo, lo0); end
  endtask
`endif

  task automatic test_back_to_back();
    int lat, bcnt;
    @(negedge clk);
    launch(OP_MULTU, 32'd3, 32'd5);
    wait_done(lat, bcnt);
    checks++; if (bus.lo !== 32'd15) begin errors++; $display("FAIL b2b_first_lo: got %h expected %h", bus.lo, 32'd15); end
    launch(OP_MULTU, 32'd6, 32'd7);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_in_done: got busy=%b expected 1", bus.busy); end
    wait_done(lat, bcnt);
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency: got %0d expected 34", lat); end
    checks++; if (bus.lo !== 32'd42 || bus.hi !== 32'd0) begin errors++; $display("FAIL b2b_result: got %h_%h expected %h_%h", bus.hi, bus.lo, 32'd0, 32'd42); end
  endtask

  task automatic test_ignore_start();
    int lat, act;
    @(negedge clk);
    launch(OP_MULT, 32'd3, 32'd5);
    lat = 1;
    while (!bus.done && lat < 200) begin
      if (lat == 5) begin
        bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'h64; bus.b = 32'h0;
      end else if (lat == 6) begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    checks++; if (lat !== 34) begin errors++; $display("FAIL ignore_latency: got %0d expected 34", lat); end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'd15) begin errors++; $display("FAIL ignore_result: got %h_%h expected %h_%h", bus.hi, bus.lo, 32'h0, 32'd15); end
    act = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.busy || bus.done) act++;
    end
    checks++; if (act !== 0) begin errors++; $display("FAIL ignore_not_queued: got %0d active cycles expected 0", act); end
  endtask

  task automatic test_flush();
    int act;
    @(negedge clk);
    launch(OP_MULT, 32'd2, 32'd2);
    for (int n = 1; n < 10; n++) @(negedge clk);
    bus.flush = 1'b1;
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL flush_done: got %b expected 0", bus.done); end
    act = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy || bus.done) act++;
    end
    checks++; if (act !== 0) begin errors++; $display("FAIL flush_quiet: got %0d active cycles expected 0", act); end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'd15) begin errors++; $display("FAIL flush_hilo_kept: got %h_%h expected %h_%h", bus.hi, bus.lo, 32'h0, 32'd15); end
  endtask

  task automatic test_reset_midop();
    int act;
    @(negedge clk);
    launch(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int n = 1; n < 10; n++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL rstmid_hilo: got %h_%h expected 0_0", bus.hi, bus.lo); end
    act = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.busy || bus.done) act++;
    end
    checks++; if (act !== 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", act); end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL rstmid_hilo_after: got %h_%h expected 0_0", bus.hi, bus.lo); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    test_reset();
    test_mt();
    test_mult();
    test_div();
    test_div_by_zero();
`ifdef MULDIV_ACCUM_EN
    test_accum();
`else
    test_noop();
`endif
    test_back_to_back();
    test_ignore_start();
    test_flush();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
